// File: rtl/traceback_direction_reader.sv
`default_nettype none
// ============================================================================
// Module      : traceback_direction_reader
// Description : Walks the filled direction matrix from cell (N,N) back to
//               (0,0). Each cell costs one synchronous RAM read. The stored
//               symbol is checked for legality and then emitted as one
//               traceback step over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module traceback_direction_reader #(
    parameter int         N           = 128,
    parameter int         BitAddr     = $clog2(N + 1),
    parameter int         addr_lenght = $clog2((N + 1) * (N + 1)),
    parameter logic [2:0] DIAG        = 3'b001,
    parameter logic [2:0] UP          = 3'b010,
    parameter logic [2:0] LEFT        = 3'b100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   rd_en,
    output logic [addr_lenght-1:0] rd_addr,
    input  logic [2:0]             rd_data,
    output logic                   step_valid,
    input  logic                   step_ready,
    output logic [2:0]             step_sym,
    output logic [BitAddr:0]       step_i,
    output logic [BitAddr:0]       step_j,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [BitAddr:0]       step_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_CW = BitAddr + 1;
    localparam int c_AW = addr_lenght;

    localparam logic [BitAddr:0]       c_N    = c_CW'(N);
    localparam logic [BitAddr:0]       c_ONE  = c_CW'(1);
    localparam logic [addr_lenght-1:0] c_ROW  = c_AW'(N + 1);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_READ = 3'd1;
    localparam logic [2:0] c_S_CAPT = 3'd2;
    localparam logic [2:0] c_S_EMIT = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;
    localparam logic [2:0] c_S_ERR  = 3'd5;

    // ------------------------------------------------------------------
    // State and walk coordinates
    // ------------------------------------------------------------------
    logic [2:0]             r_state;
    logic [BitAddr:0]       r_i;
    logic [BitAddr:0]       r_j;

    logic [2:0]             w_state_next;
    logic [BitAddr:0]       w_i_load;
    logic [BitAddr:0]       w_j_load;
    logic [BitAddr:0]       w_i_dec;
    logic [BitAddr:0]       w_j_dec;
    logic                   w_handshake;
    logic                   w_start_ok;
    logic                   w_legal;
    logic [addr_lenght-1:0] w_rd_addr_next;

    assign w_handshake = (r_state == c_S_EMIT) && step_valid && step_ready;
    assign w_start_ok  = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));

    // Decide whether the freshly read symbol may be followed from (i,j)
    always_comb begin
        w_legal = 1'b0;
        case (rd_data)
            DIAG:    w_legal = (r_i != '0) && (r_j != '0);
            UP:      w_legal = (r_i != '0);
            LEFT:    w_legal = (r_j != '0);
            default: w_legal = 1'b0;
        endcase
    end

    // Coordinates after following the accepted step
    always_comb begin
        w_i_dec = r_i;
        w_j_dec = r_j;
        if ((step_sym == DIAG) || (step_sym == UP)) begin
            w_i_dec = r_i - c_ONE;
        end
        if ((step_sym == DIAG) || (step_sym == LEFT)) begin
            w_j_dec = r_j - c_ONE;
        end
    end

    // Next-state and coordinate-load selection
    always_comb begin
        w_state_next = r_state;
        w_i_load     = r_i;
        w_j_load     = r_j;
        case (r_state)
            c_S_IDLE, c_S_DONE: begin
                if (start) begin
                    w_i_load     = c_N;
                    w_j_load     = c_N;
                    w_state_next = (N == 0) ? c_S_DONE : c_S_READ;
                end
            end
            c_S_READ: begin
                w_state_next = c_S_CAPT;
            end
            c_S_CAPT: begin
                w_state_next = w_legal ? c_S_EMIT : c_S_ERR;
            end
            c_S_EMIT: begin
                if (w_handshake) begin
                    w_i_load     = w_i_dec;
                    w_j_load     = w_j_dec;
                    w_state_next = ((w_i_dec == '0) && (w_j_dec == '0)) ? c_S_DONE : c_S_READ;
                end
            end
            c_S_ERR: begin
                w_state_next = c_S_ERR;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // Row-major address of the next cell to read; max (N+1)^2-1 never wraps
    assign w_rd_addr_next = c_AW'(w_j_load) + (c_ROW * c_AW'(w_i_load));

    // FSM state and walk coordinates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
        end else begin
            r_state <= w_state_next;
            r_i     <= w_i_load;
            r_j     <= w_j_load;
        end
    end

    // Status and RAM-control outputs registered from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            step_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            rd_en      <= (w_state_next == c_S_READ);
            step_valid <= (w_state_next == c_S_EMIT);
            busy       <= (w_state_next == c_S_READ) ||
                          (w_state_next == c_S_CAPT) ||
                          (w_state_next == c_S_EMIT);
            done       <= (w_state_next == c_S_DONE);
            // ERR is only left through reset, so this level is sticky
            error      <= (w_state_next == c_S_ERR);
            if (w_state_next == c_S_READ) begin
                rd_addr <= w_rd_addr_next;
            end
        end
    end

    // Step payload capture and accepted-step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            step_sym   <= '0;
            step_i     <= '0;
            step_j     <= '0;
            step_count <= '0;
        end else begin
            if (r_state == c_S_CAPT) begin
                step_sym <= rd_data;
                step_i   <= r_i;
                step_j   <= r_j;
            end
            if (w_start_ok) begin
                step_count <= '0;
            end else if (w_handshake) begin
                step_count <= step_count + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traceback_direction_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_traceback_direction_reader
// Description : Directed bench for traceback_direction_reader with N=4.
//               Expected walk steps live in a table; multi-cycle corners
//               (backpressure, stray start, reset, illegal symbols) are
//               hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traceback_direction_reader;

    localparam int         c_N    = 4;
    localparam int         c_BA   = $clog2(c_N + 1);
    localparam int         c_AW   = $clog2((c_N + 1) * (c_N + 1));
    localparam logic [2:0] c_DIAG = 3'b001;
    localparam logic [2:0] c_UP   = 3'b010;
    localparam logic [2:0] c_LEFT = 3'b100;

    logic              clk;
    logic              rst;
    logic              start;
    logic              rd_en;
    logic [c_AW-1:0]   rd_addr;
    logic [2:0]        rd_data;
    logic              step_valid;
    logic              step_ready;
    logic [2:0]        step_sym;
    logic [c_BA:0]     step_i;
    logic [c_BA:0]     step_j;
    logic              busy;
    logic              done;
    logic              error;
    logic [c_BA:0]     step_count;

    traceback_direction_reader #(
        .N (c_N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_sym   (step_sym),
        .step_i     (step_i),
        .step_j     (step_j),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direction RAM model: synchronous read, data valid the cycle after rd_en
    logic [2:0] ram [25];
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [4:0] addr;
        logic [2:0] sym;
        logic [3:0] i;
        logic [3:0] j;
    } step_t;

    step_t tbl [13];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_step(input int k, input int a, input logic [2:0] s, input int i, input int j);
        tbl[k].addr = 5'(a);
        tbl[k].sym  = s;
        tbl[k].i    = 4'(i);
        tbl[k].j    = 4'(j);
    endtask

    // cfg 0: all-DIAG, 1: mixed, 2: illegal 000 at (4,4), 3: LEFT reaches (2,0)
    task automatic load_ram(input int cfg);
        for (int a = 0; a < 25; a++) ram[a] = 3'b000;
        case (cfg)
            0: begin ram[24] = c_DIAG; ram[18] = c_DIAG; ram[12] = c_DIAG; ram[6] = c_DIAG; end
            1: begin ram[24] = c_LEFT; ram[23] = c_UP; ram[18] = c_DIAG; ram[12] = c_DIAG; ram[6] = c_DIAG; end
            2: begin ram[24] = 3'b000; end
            default: begin ram[24] = c_DIAG; ram[18] = c_DIAG; ram[12] = c_LEFT; ram[11] = c_LEFT; ram[10] = c_LEFT; end
        endcase
    endtask

    task automatic check_zero(input string name);
        check(name, 32'({rd_en, rd_addr, step_valid, step_sym, step_i, step_j,
                         busy, done, error, step_count}), 32'd0);
    endtask

    task automatic wait_rd_en();
        int t = 0;
        while (!rd_en && t < 20) begin tick(); t++; end
        if (!rd_en) check("rd_en_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!step_valid && t < 20) begin tick(); t++; end
        if (!step_valid) check("step_valid_timeout", 32'd0, 32'd1);
    endtask

    // Start a walk and follow n table entries; hold_k stalls that step 5 cycles
    task automatic do_walk(input int first, input int n, input int hold_k,
                           input bit poke, input bit expect_done);
        int last_cyc = 0;
        start = 1'b1;
        tick();
        check("start_rd_en", 32'(rd_en), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_count_clr", 32'(step_count), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            wait_rd_en();
            check("rd_addr", 32'(rd_addr), 32'(tbl[first+k].addr));
            if (k > 0 && (k - 1) != hold_k) check("rd_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            if (poke) start = 1'b1;
            tick();
            wait_valid();
            check("step_sym", 32'(step_sym), 32'(tbl[first+k].sym));
            check("step_i", 32'(step_i), 32'(tbl[first+k].i));
            check("step_j", 32'(step_j), 32'(tbl[first+k].j));
            if (k == hold_k) begin
                step_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    check("hold_valid", 32'(step_valid), 32'd1);
                    check("hold_payload", 32'({step_sym, step_i, step_j}),
                          32'({tbl[first+k].sym, tbl[first+k].i, tbl[first+k].j}));
                    check("hold_no_rd_en", 32'(rd_en), 32'd0);
                end
                step_ready = 1'b1;
            end
            if (poke) start = 1'b1;
            tick();
            check("valid_drop", 32'(step_valid), 32'd0);
            check("step_count", 32'(step_count), 32'(k + 1));
        end
        if (expect_done) begin
            check("walk_done", 32'(done), 32'd1);
            check("walk_idle_busy", 32'(busy), 32'd0);
            check("walk_no_error", 32'(error), 32'd0);
        end
    endtask

    initial begin
        set_step(0, 24, c_DIAG, 4, 4);
        set_step(1, 18, c_DIAG, 3, 3);
        set_step(2, 12, c_DIAG, 2, 2);
        set_step(3,  6, c_DIAG, 1, 1);
        set_step(4, 24, c_LEFT, 4, 4);
        set_step(5, 23, c_UP,   4, 3);
        set_step(6, 18, c_DIAG, 3, 3);
        set_step(7, 12, c_DIAG, 2, 2);
        set_step(8,  6, c_DIAG, 1, 1);
        set_step(9, 24, c_DIAG, 4, 4);
        set_step(10, 18, c_DIAG, 3, 3);
        set_step(11, 12, c_LEFT, 2, 2);
        set_step(12, 11, c_LEFT, 2, 1);

        rst        = 1'b1;
        start      = 1'b0;
        step_ready = 1'b1;
        load_ram(0);
        repeat (3) tick();
        check_zero("reset_outputs");
        rst = 1'b0;
        tick();
        check_zero("idle_outputs");

        // All-DIAG walk
        do_walk(0, 4, -1, 1'b0, 1'b1);

        // Mixed walk, started from DONE
        load_ram(1);
        do_walk(4, 5, -1, 1'b0, 1'b1);

        // Backpressure at the first EMIT
        do_walk(4, 5, 0, 1'b0, 1'b1);

        // Stray start pulses during READ and EMIT
        load_ram(0);
        do_walk(0, 4, -1, 1'b1, 1'b1);

        // Reset during the second EMIT
        start = 1'b1;
        tick();
        repeat (5) tick();
        check("mid_emit_valid", 32'(step_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_zero("midwalk_reset_outputs");
        rst = 1'b0;
        tick();
        check_zero("post_reset_idle");
        do_walk(0, 4, -1, 1'b0, 1'b1);

        // Illegal symbol 000 at (4,4)
        load_ram(2);
        start = 1'b1;
        tick();
        check("ill0_rd_addr", 32'(rd_addr), 32'd24);
        tick();
        check("ill0_capt_valid", 32'(step_valid), 32'd0);
        tick();
        check("ill0_error", 32'(error), 32'd1);
        check("ill0_valid", 32'(step_valid), 32'd0);
        check("ill0_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        repeat (3) begin
            tick();
            check("ill0_start_ignored", 32'({rd_en, step_valid, busy}), 32'd0);
        end
        check("ill0_sticky", 32'(error), 32'd1);
        rst = 1'b1;
        tick();
        check_zero("ill0_reset");
        rst = 1'b0;
        tick();

        // LEFT stored at (2,0) on the path
        load_ram(3);
        do_walk(9, 4, -1, 1'b0, 1'b0);
        wait_rd_en();
        check("ill1_rd_addr", 32'(rd_addr), 32'd10);
        tick();
        tick();
        check("ill1_error", 32'(error), 32'd1);
        check("ill1_valid", 32'(step_valid), 32'd0);
        check("ill1_done", 32'(done), 32'd0);
        check("ill1_count", 32'(step_count), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
